riscv_multicycle_ctrl: RTL
==========================

Name: riscv_multicycle_ctrl

Overview:
- Control FSM that sequences a shared-ALU, unified-memory multicycle RV32I datapath, one instruction every 3-5 cycles.
- Reuses the datapath's existing 4-bit ALUControl and 2-bit ImmSrc encodings; only the datapath's enable and mux controls are new.
- Supports lw, sw, R-type, I-type ALU, beq, bne and jal. Memory accesses stall on a ready handshake.

Parameters:
- none

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- op  in  7  Instr[6:0], taken from the instruction register
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory has completed the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction and OldPC register enable
- ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1
- ALUSrcB  out  2  ALU B select: 00=rs2, 01=ImmExt, 10=constant 4
- ImmSrc  out  2  immediate format: 00=I, 01=S, 10=B, 11=J
- RegWrite  out  1  register file write enable
- ALUControl  out  4  ALU operation
- Illegal  out  1  one-cycle pulse on an unsupported opcode

Behaviour:
- State register: async clear to FETCH while reset is low; otherwise advances on the rising edge of clk.
- While reset is low: PCWrite, IRWrite, RegWrite, MemWrite and Illegal are all 0. Every other output takes its FETCH value.
- ImmSrc is combinational from op: lw/I-ALU=00, sw=01, branch=10, jal=11, any other op=00.
- Outputs are Moore, decoded from state only. The exceptions are PCWrite, IRWrite and the branch condition, which also use MemReady, Zero and funct3.
- Unlisted controls are 0 (muxes are don't-care but must be driven to 0).
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10.
  - IRWrite=MemReady, PCWrite=MemReady.
  - Next state: DECODE if MemReady, else stay in FETCH.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, add (precomputes the branch target into ALUOut).
  - Next state by op:
    - 0000011 and 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - any other op -> FETCH, with Illegal=1 for this cycle
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next state: MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Wait for MemReady, then -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held every cycle until MemReady, then -> FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, function-decoded ALU op. Next state: ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, function-decoded ALU op. Next state: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state: FETCH.
- JAL:
  - ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1.
  - The PC takes the target held in ALUOut; ALUOut then takes OldPC+4.
  - Next state: ALUWB.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite = (funct3=000 & Zero) | (funct3=001 & !Zero); other funct3 values give not-taken.
  - Next state: FETCH.
- ALU decode:
  - ALUOp add -> ADD; ALUOp sub -> SUB.
  - Function-decoded op, by funct3:
    - 000: SUB only if R-type and funct7b5=1, else ADD (addi ignores bit 30)
    - 001: SLL
    - 010: SLT
    - 011: SLTU
    - 100: XOR
    - 101: SRA if funct7b5=1, else SRL
    - 110: OR
    - 111: AND
- ALUControl encoding: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLT=0101, SLL=0110, SRL=0111, SRA=1000, SLTU=1001.
- Cycle counts with MemReady held at 1:
  - R-type and I-type: 4
  - lw: 5
  - sw: 4
  - beq/bne: 3
  - jal: 4
- A reset asserted mid-instruction abandons it immediately. No write strobe is asserted in the reset cycle or the cycle after.

Decomposition:
- Shared package riscv_pkg holds:
  - state enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL
  - ALUControl constants
  - opcode constants
  - ALUOp enum
- One sub-module: riscv_mc_aludec (ALUOp, funct3, funct7b5, op bit 5 -> ALUControl), purely combinational.

Test Plan:
- Reset low mid-MEMWRITE -> MemWrite drops to 0 asynchronously. After release, the FSM is in FETCH and PCWrite=IRWrite=MemReady.
- add x3,x1,x2 (op=0110011, funct3=000, funct7b5=0), MemReady=1 -> 4 cycles. ALUControl=0000 in EXECR, RegWrite=1 only in cycle 4. With funct7b5=1 -> ALUControl=0001.
- lw (op=0000011) with MemReady low for 3 cycles in MEMREAD -> AdrSrc=1 held throughout. MEMWB follows the ready cycle, ResultSrc=01, RegWrite=1, 8 cycles total.
- beq (funct3=000): Zero=1 -> PCWrite=1 in BRANCH, ALUControl=0001. Zero=0 -> PCWrite=0. bne (funct3=001) gives the inverse.
- jal (op=1101111) -> ImmSrc=11. JAL state: PCWrite=1, ALUSrcA=01, ALUSrcB=10. ALUWB then asserts RegWrite.
- op=1111111 in DECODE -> Illegal=1 for exactly one cycle, then FETCH. RegWrite, MemWrite and PCWrite stay 0 throughout.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I controller.
//   state_t    : controller FSM states
//   alu_op_t   : coarse ALU request from the FSM to the ALU decoder
//   ALU_*      : 4-bit ALUControl encodings understood by the datapath ALU
//   OP_*       : RV32I major opcodes handled by the controller
//   RES_/SRCA_/SRCB_/IMM_* : datapath mux select encodings
package riscv_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMREAD,
      MEMWB,
      MEMWRITE,
      EXECR,
      EXECI,
      ALUWB,
      BRANCH,
      JAL
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD  = 2'b00,
      ALUOP_SUB  = 2'b01,
      ALUOP_FUNC = 2'b10
   } alu_op_t;

   // ALUControl encodings
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLL  = 4'b0110;
   localparam logic [3:0] ALU_SRL  = 4'b0111;
   localparam logic [3:0] ALU_SRA  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   // Major opcodes
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // ResultSrc
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // ALUSrcA
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   // ALUSrcB
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // ImmSrc
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // Immediate format selected purely from the opcode; unknown opcodes fall back to I.
   function automatic logic [1:0] imm_src_for(input logic [6:0] op);
      logic [1:0] imm;
      imm = IMM_I;
      case (op)
         OP_STORE:  imm = IMM_S;
         OP_BRANCH: imm = IMM_B;
         OP_JAL:    imm = IMM_J;
         default:   imm = IMM_I;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_if.sv
// Bundle of signals between the multicycle controller and its datapath.
//   Datapath -> controller : op, funct3, funct7b5, Zero, MemReady
//   Controller -> datapath : PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
//                            ALUSrcB, ImmSrc, RegWrite, ALUControl, Illegal
// master is the controller side, slave the datapath side.
interface riscv_multicycle_ctrl_if;

   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       MemReady;

   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ImmSrc;
   logic       RegWrite;
   logic [3:0] ALUControl;
   logic       Illegal;

   modport master (
      input  op, funct3, funct7b5, Zero, MemReady,
      output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
             RegWrite, ALUControl, Illegal
   );

   modport slave (
      output op, funct3, funct7b5, Zero, MemReady,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
             RegWrite, ALUControl, Illegal
   );

endinterface

// File: rtl/riscv_mc_aludec.sv
// ALU decoder for the multicycle controller (purely combinational).
//   alu_op_i      : add / sub request, or decode from the instruction fields
//   funct3_i      : Instr[14:12]
//   funct7b5_i    : Instr[30]
//   op5_i         : Instr[5], set for R-type and clear for I-type ALU ops
//   alu_control_o : 4-bit ALUControl to the datapath ALU
module riscv_mc_aludec
   import riscv_pkg::*;
(
   input  alu_op_t    alu_op_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   input  logic       op5_i,
   output logic [3:0] alu_control_o
);

   logic [3:0] func_ctrl;

   always_comb begin
      func_ctrl = ALU_ADD;
      unique case (funct3_i)
         // addi has no sub form, so bit 30 only matters for R-type
         3'b000:  func_ctrl = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
         3'b001:  func_ctrl = ALU_SLL;
         3'b010:  func_ctrl = ALU_SLT;
         3'b011:  func_ctrl = ALU_SLTU;
         3'b100:  func_ctrl = ALU_XOR;
         3'b101:  func_ctrl = funct7b5_i ? ALU_SRA : ALU_SRL;
         3'b110:  func_ctrl = ALU_OR;
         3'b111:  func_ctrl = ALU_AND;
         default: func_ctrl = ALU_ADD;
      endcase
   end

   always_comb begin
      alu_control_o = ALU_ADD;
      case (alu_op_i)
         ALUOP_ADD:  alu_control_o = ALU_ADD;
         ALUOP_SUB:  alu_control_o = ALU_SUB;
         ALUOP_FUNC: alu_control_o = func_ctrl;
         default:    alu_control_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Control FSM for a shared-ALU, unified-memory multicycle RV32I datapath.
//   clk      : rising-edge clock
//   reset    : asynchronous, active-low; forces FETCH and suppresses all write enables
//   ctrl_bus : instruction fields, Zero and MemReady in; datapath enables and mux
//              selects out (see riscv_multicycle_ctrl_if)
// Supports lw, sw, R-type, I-type ALU, beq, bne and jal. Outputs are Moore except
// PCWrite/IRWrite in FETCH (MemReady) and PCWrite in BRANCH (Zero, funct3).
module riscv_multicycle_ctrl
   import riscv_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   riscv_multicycle_ctrl_if.master ctrl_bus
);

   state_t     state_q, state_d;

   logic       pc_write;
   logic       adr_src;
   logic       mem_write;
   logic       ir_write;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic       reg_write;
   logic       illegal;
   alu_op_t    alu_op;
   logic       branch_taken;
   logic [3:0] alu_control;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Unsupported funct3 values (blt, bge, ...) fall through as not-taken.
   always_comb begin
      branch_taken = 1'b0;
      case (ctrl_bus.funct3)
         3'b000:  branch_taken = ctrl_bus.Zero;
         3'b001:  branch_taken = !ctrl_bus.Zero;
         default: branch_taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      reg_write  = 1'b0;
      illegal    = 1'b0;
      alu_op     = ALUOP_ADD;

      case (state_q)
         FETCH: begin
            // PC+4 is written straight from the ALU result as the instruction lands
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            ir_write   = ctrl_bus.MemReady;
            pc_write   = ctrl_bus.MemReady;
            if (ctrl_bus.MemReady) begin
               state_d = DECODE;
            end
         end
         DECODE: begin
            // OldPC + imm lands in ALUOut, ready as a branch or jump target
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (ctrl_bus.op)
               OP_LOAD, OP_STORE: state_d = MEMADR;
               OP_RTYPE:          state_d = EXECR;
               OP_ITYPE:          state_d = EXECI;
               OP_BRANCH:         state_d = BRANCH;
               OP_JAL:            state_d = JAL;
               default: begin
                  state_d = FETCH;
                  illegal = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            state_d   = (ctrl_bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            adr_src    = 1'b1;
            result_src = RES_ALUOUT;
            if (ctrl_bus.MemReady) begin
               state_d = MEMWB;
            end
         end
         MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
            state_d    = FETCH;
         end
         MEMWRITE: begin
            // strobe stays up until memory accepts the store
            adr_src    = 1'b1;
            result_src = RES_ALUOUT;
            mem_write  = 1'b1;
            if (ctrl_bus.MemReady) begin
               state_d = FETCH;
            end
         end
         EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_RS2;
            alu_op    = ALUOP_FUNC;
            state_d   = ALUWB;
         end
         EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNC;
            state_d   = ALUWB;
         end
         ALUWB: begin
            result_src = RES_ALUOUT;
            reg_write  = 1'b1;
            state_d    = FETCH;
         end
         JAL: begin
            // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALUOUT;
            pc_write   = 1'b1;
            state_d    = ALUWB;
         end
         BRANCH: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_RS2;
            alu_op     = ALUOP_SUB;
            result_src = RES_ALUOUT;
            pc_write   = branch_taken;
            state_d    = FETCH;
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   riscv_mc_aludec u_aludec (
      .alu_op_i      (alu_op),
      .funct3_i      (ctrl_bus.funct3),
      .funct7b5_i    (ctrl_bus.funct7b5),
      .op5_i         (ctrl_bus.op[5]),
      .alu_control_o (alu_control)
   );

   // Reset holds the state in FETCH; the gating below also kills the MemReady-driven
   // strobes so nothing is written while reset is low.
   assign ctrl_bus.PCWrite    = pc_write  & reset;
   assign ctrl_bus.IRWrite    = ir_write  & reset;
   assign ctrl_bus.RegWrite   = reg_write & reset;
   assign ctrl_bus.MemWrite   = mem_write & reset;
   assign ctrl_bus.Illegal    = illegal   & reset;
   assign ctrl_bus.AdrSrc     = adr_src;
   assign ctrl_bus.ResultSrc  = result_src;
   assign ctrl_bus.ALUSrcA    = alu_src_a;
   assign ctrl_bus.ALUSrcB    = alu_src_b;
   assign ctrl_bus.ImmSrc     = imm_src_for(ctrl_bus.op);
   assign ctrl_bus.ALUControl = alu_control;

endmodule
